cpu_ex_host_ctrl: RTL and testbench

Host-side initiator for the CPU's external memory port. Converts burst commands from the host link (valid/ready command, write-data and read-data streams) into the single-word `ex_` strobes that load instruction memory, write data memory and read data memory. It sits between the host interface and the CPU top: it drives `ex_im_wrt_en`, `ex_mem_wrt_en`, `ex_mem_rd_en`, `ex_addr` and `ex_wrt_data`, and it consumes `ex_rd_data`.

---
 rtl/cpu_ex_host_ctrl.sv | 148 ++++++++++++++
 tb/tb_cpu_ex_host_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ex_host_ctrl.sv
// cpu_ex_host_ctrl: turns host burst commands into single-word ex_ strobes for IM/DM load and DM read-back
module cpu_ex_host_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ex_im_wrt_en,
  output logic              ex_mem_wrt_en,
  output logic              ex_mem_rd_en,
  output logic [ADDR_W-1:0] ex_addr,
  output logic [DATA_W-1:0] ex_wrt_data,
  input  logic [DATA_W-1:0] ex_rd_data
);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d, cnt_q, cnt_d, n;
  logic [ADDR_W-1:0] addr_q, addr_d, ex_addr_q, ex_addr_d;
  logic [LEN_W-1:0] rem_q, rem_d, cur_rem;
  logic [DATA_W-1:0] f0_q, f0_d, f1_q, f1_d, ex_wrt_data_q, ex_wrt_data_d;
  logic more_q, more_d, infl_q, infl_d;
  logic im_q, im_d, mw_q, mw_d, mr_q, mr_d, done_q, done_d, err_q, err_d;
  logic cmd_fire, wr_fire, pop, rd_go;
  logic [2:0] occ;
  assign cmd_ready     = state_q == IDLE;
  assign wdata_ready   = state_q == WRITE;
  assign busy          = state_q != IDLE;
  assign rdata_valid   = cnt_q != 2'd0;
  assign rdata         = f0_q;
  assign done          = done_q;
  assign err           = err_q;
  assign ex_im_wrt_en  = im_q;
  assign ex_mem_wrt_en = mw_q;
  assign ex_mem_rd_en  = mr_q;
  assign ex_addr       = ex_addr_q;
  assign ex_wrt_data   = ex_wrt_data_q;
  assign cmd_fire      = cmd_valid & cmd_ready;
  assign wr_fire       = wdata_valid & wdata_ready;
  assign pop           = rdata_valid & rdata_ready;
  assign n             = cnt_q - {1'b0, pop};
  // a new read is only issued if every word already requested still has a FIFO slot after this cycle's pop
  assign occ           = {1'b0, n} + {2'b0, infl_q} + {2'b0, mr_q};
  assign rd_go         = (cmd_fire && cmd_op == 2'b10) || (state_q == READ && more_q && occ < 3'd2);
  assign cur_rem       = cmd_fire ? cmd_len : rem_q;
  // next-state, strobe and FIFO update logic
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    more_d        = more_q;
    infl_d        = mr_q;
    cnt_d         = n + {1'b0, infl_q};
    f0_d          = pop ? f1_q : f0_q;
    f1_d          = f1_q;
    ex_addr_d     = ex_addr_q;
    ex_wrt_data_d = ex_wrt_data_q;
    im_d          = 1'b0;
    mw_d          = 1'b0;
    mr_d          = rd_go;
    done_d        = 1'b0;
    err_d         = 1'b0;
    if (infl_q) begin
      if (n == 2'd0) f0_d = ex_rd_data;
      else f1_d = ex_rd_data;
    end
    if (cmd_fire) begin
      op_d    = cmd_op;
      addr_d  = cmd_addr;
      rem_d   = cmd_len;
      state_d = cmd_op[1] ? (cmd_op[0] ? IDLE : READ) : WRITE;
      err_d   = cmd_op == 2'b11;
    end
    if (wr_fire) begin
      im_d          = op_q == 2'b00;
      mw_d          = op_q == 2'b01;
      ex_addr_d     = addr_q;
      ex_wrt_data_d = wdata;
      addr_d        = addr_q + ADDR_W'(4);
      rem_d         = rem_q - LEN_W'(1);
      done_d        = rem_q == '0;
      state_d       = rem_q == '0 ? IDLE : WRITE;
    end
    if (rd_go) begin
      ex_addr_d = cmd_fire ? cmd_addr : addr_q;
      addr_d    = ex_addr_d + ADDR_W'(4);
      more_d    = cur_rem != '0;
      rem_d     = cur_rem - LEN_W'(1);
    end
    if (state_q == READ && pop && n == 2'd0 && !infl_q && !mr_q && !more_q) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  // state and registered outputs, cleared asynchronously so a burst is abandoned at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= '0;
      addr_q        <= '0;
      rem_q         <= '0;
      more_q        <= 1'b0;
      infl_q        <= 1'b0;
      cnt_q         <= '0;
      f0_q          <= '0;
      f1_q          <= '0;
      ex_addr_q     <= '0;
      ex_wrt_data_q <= '0;
      im_q          <= 1'b0;
      mw_q          <= 1'b0;
      mr_q          <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      more_q        <= more_d;
      infl_q        <= infl_d;
      cnt_q         <= cnt_d;
      f0_q          <= f0_d;
      f1_q          <= f1_d;
      ex_addr_q     <= ex_addr_d;
      ex_wrt_data_q <= ex_wrt_data_d;
      im_q          <= im_d;
      mw_q          <= mw_d;
      mr_q          <= mr_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end
endmodule

// File: tb/tb_cpu_ex_host_ctrl.sv
// tb_cpu_ex_host_ctrl: directed scenario bench for cpu_ex_host_ctrl
module tb_cpu_ex_host_ctrl;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_op = 0;
  logic [15:0] cmd_addr = 0;
  logic [7:0] cmd_len = 0;
  logic wdata_valid = 0, wdata_ready;
  logic [31:0] wdata = 0;
  logic rdata_valid, rdata_ready = 0;
  logic [31:0] rdata;
  logic busy, done, err, ex_im_wrt_en, ex_mem_wrt_en, ex_mem_rd_en;
  logic [15:0] ex_addr;
  logic [31:0] ex_wrt_data, ex_rd_data = 32'hDEADBEEF;
  int cyc = 0, compared = 0, mismatched = 0;
  typedef struct { int cyc; int k; logic [15:0] a; logic [31:0] d; } ev_t;
  ev_t evq[$];
  int done_q[$], err_q[$], popc[$];
  logic [31:0] popq[$];

  cpu_ex_host_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .wdata(wdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .busy(busy), .done(done), .err(err), .ex_im_wrt_en(ex_im_wrt_en), .ex_mem_wrt_en(ex_mem_wrt_en),
    .ex_mem_rd_en(ex_mem_rd_en), .ex_addr(ex_addr), .ex_wrt_data(ex_wrt_data), .ex_rd_data(ex_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // data memory model: mem[a] = a + 1, returned the cycle after the read strobe
  always @(posedge clk) ex_rd_data <= ex_mem_rd_en ? 32'(ex_addr) + 32'd1 : 32'hDEADBEEF;
  // event log taken mid-cycle
  always @(negedge clk) if (!rst) begin
    if (ex_im_wrt_en || ex_mem_wrt_en || ex_mem_rd_en)
      evq.push_back('{cyc, ex_mem_rd_en ? 2 : ex_mem_wrt_en ? 1 : 0, ex_addr, ex_wrt_data});
    if (done) done_q.push_back(cyc);
    if (err) err_q.push_back(cyc);
    if (rdata_valid && rdata_ready) begin popq.push_back(rdata); popc.push_back(cyc); end
    compared++;
    if ($countones({ex_im_wrt_en, ex_mem_wrt_en, ex_mem_rd_en}) > 1) begin
      mismatched++;
      $display("FAIL excl_strobes cyc=%0d got %b want at most one", cyc, {ex_im_wrt_en, ex_mem_wrt_en, ex_mem_rd_en});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear_logs;
    evq.delete(); done_q.delete(); err_q.delete(); popq.delete(); popc.delete();
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] a, input logic [7:0] l, output int acc);
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_len = l; acc = cyc;
    tick;
    cmd_valid = 0;
  endtask

  task automatic test_reset;
    #2;
    compared++;
    if ({cmd_ready, wdata_ready, rdata_valid, busy, done, err, ex_im_wrt_en, ex_mem_wrt_en, ex_mem_rd_en} !== 9'b100000000) begin
      mismatched++;
      $display("FAIL reset_ctrl got %b want 100000000", {cmd_ready, wdata_ready, rdata_valid, busy, done, err, ex_im_wrt_en, ex_mem_wrt_en, ex_mem_rd_en});
    end
    compared++;
    if ({ex_addr, ex_wrt_data, rdata} !== 80'd0) begin
      mismatched++;
      $display("FAIL reset_data got %h want 0", {ex_addr, ex_wrt_data, rdata});
    end
    tick; tick;
    rst = 0;
    tick;
  endtask

  task automatic test_im_write;
    int acc;
    clear_logs();
    send_cmd(2'b00, 16'h0000, 8'd3, acc);
    for (int i = 0; i < 4; i++) begin
      wdata_valid = 1; wdata = 32'hA0 + 32'(i);
      tick;
    end
    wdata_valid = 0;
    compared++;
    if ({cmd_ready, done, ex_im_wrt_en} !== 3'b111) begin
      mismatched++;
      $display("FAIL im_last_cycle got ready/done/strobe=%b want 111", {cmd_ready, done, ex_im_wrt_en});
    end
    tick; tick;
    compared++;
    if (evq.size() != 4) begin
      mismatched++;
      $display("FAIL im_count got %0d want 4", evq.size());
    end
    for (int i = 0; i < evq.size() && i < 4; i++) begin
      compared++;
      if (evq[i].cyc != acc + 2 + i || evq[i].k != 0 || evq[i].a !== 16'(4 * i) || evq[i].d !== 32'hA0 + 32'(i)) begin
        mismatched++;
        $display("FAIL im_word%0d got cyc=%0d k=%0d a=%h d=%h want cyc=%0d k=0 a=%h d=%h",
                 i, evq[i].cyc, evq[i].k, evq[i].a, evq[i].d, acc + 2 + i, 16'(4 * i), 32'hA0 + 32'(i));
      end
    end
    compared++;
    if (done_q.size() != 1 || done_q[0] != acc + 5) begin
      mismatched++;
      $display("FAIL im_done got n=%0d first=%0d want n=1 at %0d", done_q.size(), done_q.size() > 0 ? done_q[0] : -1, acc + 5);
    end
  endtask

  task automatic test_dm_write_gaps;
    int acc;
    clear_logs();
    send_cmd(2'b01, 16'h0040, 8'd1, acc);
    for (int i = 0; i < 4; i++) begin
      wdata_valid = (i % 2) == 1; wdata = 32'hB0 + 32'(i / 2);
      tick;
    end
    wdata_valid = 0;
    tick; tick;
    compared++;
    if (evq.size() != 2) begin
      mismatched++;
      $display("FAIL dmw_count got %0d want 2", evq.size());
    end
    for (int i = 0; i < evq.size() && i < 2; i++) begin
      compared++;
      if (evq[i].cyc != acc + 3 + 2 * i || evq[i].k != 1 || evq[i].a !== 16'h0040 + 16'(4 * i) || evq[i].d !== 32'hB0 + 32'(i)) begin
        mismatched++;
        $display("FAIL dmw_word%0d got cyc=%0d k=%0d a=%h d=%h want cyc=%0d k=1 a=%h d=%h",
                 i, evq[i].cyc, evq[i].k, evq[i].a, evq[i].d, acc + 3 + 2 * i, 16'h0040 + 16'(4 * i), 32'hB0 + 32'(i));
      end
    end
    compared++;
    if (done_q.size() != 1 || done_q[0] != acc + 5) begin
      mismatched++;
      $display("FAIL dmw_done got n=%0d want n=1 at %0d", done_q.size(), acc + 5);
    end
  endtask

  task automatic test_wrap;
    int acc;
    logic [15:0] ea;
    clear_logs();
    send_cmd(2'b01, 16'hFFF8, 8'd2, acc);
    for (int i = 0; i < 3; i++) begin
      wdata_valid = 1; wdata = 32'hC0 + 32'(i);
      tick;
    end
    wdata_valid = 0;
    tick; tick;
    compared++;
    if (evq.size() != 3) begin
      mismatched++;
      $display("FAIL wrap_count got %0d want 3", evq.size());
    end
    for (int i = 0; i < evq.size() && i < 3; i++) begin
      ea = 16'hFFF8 + 16'(4 * i);
      compared++;
      if (evq[i].k != 1 || evq[i].a !== ea || evq[i].d !== 32'hC0 + 32'(i)) begin
        mismatched++;
        $display("FAIL wrap_word%0d got k=%0d a=%h d=%h want k=1 a=%h d=%h", i, evq[i].k, evq[i].a, evq[i].d, ea, 32'hC0 + 32'(i));
      end
    end
  endtask

  task automatic test_dm_read_stall;
    int acc, t;
    clear_logs();
    rdata_ready = 0;
    send_cmd(2'b10, 16'h0100, 8'd3, acc);
    repeat (5) tick;
    compared++;
    if (evq.size() != 2 || rdata_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL rd_stall got reads=%0d valid=%b want reads=2 valid=1", evq.size(), rdata_valid);
    end
    rdata_ready = 1;
    t = 0;
    while (done !== 1'b1 && t < 40) begin tick; t++; end
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL rd_timeout got done=%b want 1 within 40 cycles", done);
    end
    compared++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rd_idle_on_done got busy=%b ready=%b want 0 1", busy, cmd_ready);
    end
    tick; tick;
    compared++;
    if (popq.size() != 4) begin
      mismatched++;
      $display("FAIL rd_pops got %0d want 4", popq.size());
    end
    for (int i = 0; i < popq.size() && i < 4; i++) begin
      compared++;
      if (popq[i] !== 32'h101 + 32'(4 * i)) begin
        mismatched++;
        $display("FAIL rd_data%0d got %h want %h", i, popq[i], 32'h101 + 32'(4 * i));
      end
    end
    for (int i = 0; i < evq.size() && i < 4; i++) begin
      compared++;
      if (evq[i].k != 2 || evq[i].a !== 16'h0100 + 16'(4 * i)) begin
        mismatched++;
        $display("FAIL rd_addr%0d got k=%0d a=%h want k=2 a=%h", i, evq[i].k, evq[i].a, 16'h0100 + 16'(4 * i));
      end
    end
    compared++;
    if (done_q.size() != 1 || popc.size() == 0 || done_q[0] != popc[popc.size() - 1] + 1 || done_q[0] != acc + 11) begin
      mismatched++;
      $display("FAIL rd_done got n=%0d at %0d want one pulse at %0d", done_q.size(), done_q.size() > 0 ? done_q[0] : -1, acc + 11);
    end
  endtask

  task automatic test_reserved;
    int acc;
    clear_logs();
    send_cmd(2'b11, 16'h1234, 8'd0, acc);
    compared++;
    if ({err, cmd_ready, busy} !== 3'b110) begin
      mismatched++;
      $display("FAIL rsv_pulse got err/ready/busy=%b want 110", {err, cmd_ready, busy});
    end
    tick;
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL rsv_one_cycle got err=%b want 0", err);
    end
    tick;
    compared++;
    if (evq.size() != 0 || err_q.size() != 1 || err_q[0] != acc + 1) begin
      mismatched++;
      $display("FAIL rsv_log got strobes=%0d errs=%0d want 0 and 1", evq.size(), err_q.size());
    end
  endtask

  task automatic test_reset_mid_read;
    int acc;
    clear_logs();
    rdata_ready = 0;
    send_cmd(2'b10, 16'h0200, 8'd7, acc);
    tick; tick;
    #2 rst = 1;
    #1;
    compared++;
    if ({cmd_ready, wdata_ready, rdata_valid, busy, done, err, ex_im_wrt_en, ex_mem_wrt_en, ex_mem_rd_en} !== 9'b100000000 ||
        {ex_addr, ex_wrt_data, rdata} !== 80'd0) begin
      mismatched++;
      $display("FAIL midrst_async got %b %h want 100000000 0",
               {cmd_ready, wdata_ready, rdata_valid, busy, done, err, ex_im_wrt_en, ex_mem_wrt_en, ex_mem_rd_en}, {ex_addr, ex_wrt_data, rdata});
    end
    rdata_ready = 1;
    repeat (2) begin
      tick;
      compared++;
      if ({rdata_valid, ex_mem_rd_en} !== 2'b00) begin
        mismatched++;
        $display("FAIL midrst_hold got valid/rd=%b want 00", {rdata_valid, ex_mem_rd_en});
      end
    end
    rst = 0;
    tick;
    compared++;
    if (evq.size() != 2 || rdata_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_after got reads=%0d valid=%b want 2 0", evq.size(), rdata_valid);
    end
    clear_logs();
    send_cmd(2'b00, 16'h0010, 8'd0, acc);
    wdata_valid = 1; wdata = 32'h55;
    tick;
    wdata_valid = 0;
    compared++;
    if ({ex_im_wrt_en, done} !== 2'b11 || ex_addr !== 16'h0010 || ex_wrt_data !== 32'h55) begin
      mismatched++;
      $display("FAIL midrst_recover got strobe/done=%b a=%h d=%h want 11 0010 00000055", {ex_im_wrt_en, done}, ex_addr, ex_wrt_data);
    end
    tick;
    compared++;
    if (busy !== 1'b0 || evq.size() != 1) begin
      mismatched++;
      $display("FAIL midrst_idle got busy=%b strobes=%0d want 0 1", busy, evq.size());
    end
  endtask

  initial begin
    test_reset();
    test_im_write();
    test_dm_write_gaps();
    test_wrap();
    test_dm_read_stall();
    test_reserved();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
